// File: rtl/shadow_reg_bank.sv
// Double-buffered register bank: software writes land in shadow registers,
// and a commit copies every dirty shadow into the active outputs in one edge.
module shadow_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter int               AW        = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      wr_en_in,
  input  logic [AW-1:0]             wr_addr_in,
  input  logic [WIDTH-1:0]          wr_data_in,
  input  logic                      clr_in,
  input  logic                      commit_in,
  input  logic [AW-1:0]             rd_addr_in,
  output logic [WIDTH-1:0]          rd_data_out,
  output logic [(2**AW)*WIDTH-1:0]  q_out,
  output logic [2**AW-1:0]          dirty_out,
  output logic                      commit_ack_out
);

  localparam int CHANNELS = 2**AW;

  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [CHANNELS-1:0] dirty;

  logic             touch;
  logic [WIDTH-1:0] touch_val;

  // Write wins over clear; both target the same shadow channel.
  assign touch     = wr_en_in | clr_in;
  assign touch_val = wr_en_in ? wr_data_in : RESET_VAL;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the arrays are reset explicitly because RESET_VAL must be visible
      // on q_out and rd_data_out right after reset; this keeps them in flops.
      for (int k = 0; k < CHANNELS; k++) begin
        shadow[k] <= RESET_VAL;
        active[k] <= RESET_VAL;
      end
      dirty          <= '0;
      commit_ack_out <= 1'b0;
      rd_data_out    <= RESET_VAL;
    end else begin
      commit_ack_out <= commit_in;
      rd_data_out    <= shadow[rd_addr_in];
      // NOTE: non-blocking assignments make a same-edge commit copy the
      // pre-write shadow value while the new write lands and stays dirty.
      for (int k = 0; k < CHANNELS; k++) begin
        if (commit_in && dirty[k]) begin
          active[k] <= shadow[k];
        end
        if (touch && (wr_addr_in == AW'(k))) begin
          shadow[k] <= touch_val;
          dirty[k]  <= 1'b1;
        end else if (commit_in) begin
          dirty[k]  <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign q_out[g*WIDTH +: WIDTH] = active[g];
  end

  assign dirty_out = dirty;

endmodule

// File: tb/tb_shadow_reg_bank.sv
// Directed-vector bench for shadow_reg_bank (WIDTH=8, AW=2, RESET_VAL=0x5A).
module tb_shadow_reg_bank;

  localparam int               WIDTH = 8;
  localparam int               AW    = 2;
  localparam logic [WIDTH-1:0] RV    = 8'h5A;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             wr_en_in = 1'b0;
  logic [AW-1:0]    wr_addr_in = '0;
  logic [WIDTH-1:0] wr_data_in = '0;
  logic             clr_in = 1'b0;
  logic             commit_in = 1'b0;
  logic [AW-1:0]    rd_addr_in = '0;
  logic [WIDTH-1:0] rd_data_out;
  logic [4*WIDTH-1:0] q_out;
  logic [3:0]       dirty_out;
  logic             commit_ack_out;

  int checks = 0;
  int errors = 0;

  shadow_reg_bank #(.WIDTH(WIDTH), .AW(AW), .RESET_VAL(RV)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .wr_en_in       (wr_en_in),
    .wr_addr_in     (wr_addr_in),
    .wr_data_in     (wr_data_in),
    .clr_in         (clr_in),
    .commit_in      (commit_in),
    .rd_addr_in     (rd_addr_in),
    .rd_data_out    (rd_data_out),
    .q_out          (q_out),
    .dirty_out      (dirty_out),
    .commit_ack_out (commit_ack_out)
  );

  always #5 clk_in = ~clk_in;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rst_in = 1'b0; wr_en_in = 1'b0; clr_in = 1'b0; commit_in = 1'b0;
  endtask

  function automatic logic [4*WIDTH-1:0] pack(input logic [WIDTH-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic test_reset();
    idle(); rst_in = 1'b1; step(); rst_in = 1'b0;
    checks++; if (q_out !== pack(RV, RV, RV, RV)) begin errors++; $display("FAIL reset_q got %h exp %h", q_out, pack(RV, RV, RV, RV)); end
    checks++; if (dirty_out !== 4'b0000) begin errors++; $display("FAIL reset_dirty got %b exp 0000", dirty_out); end
    checks++; if (commit_ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", commit_ack_out); end
    checks++; if (rd_data_out !== RV) begin errors++; $display("FAIL reset_rd got %h exp %h", rd_data_out, RV); end
  endtask

  task automatic test_basic_commit();
    idle(); wr_en_in = 1'b1; wr_addr_in = 2'd2; wr_data_in = 8'hA5; step();
    checks++; if (dirty_out !== 4'b0100) begin errors++; $display("FAIL basic_dirty got %b exp 0100", dirty_out); end
    checks++; if (q_out !== pack(RV, RV, RV, RV)) begin errors++; $display("FAIL basic_q_hold got %h exp %h", q_out, pack(RV, RV, RV, RV)); end
    checks++; if (commit_ack_out !== 1'b0) begin errors++; $display("FAIL basic_ack_early got %b exp 0", commit_ack_out); end
    idle(); commit_in = 1'b1; step();
    checks++; if (q_out !== pack(RV, RV, 8'hA5, RV)) begin errors++; $display("FAIL basic_q got %h exp %h", q_out, pack(RV, RV, 8'hA5, RV)); end
    checks++; if (dirty_out !== 4'b0000) begin errors++; $display("FAIL basic_dirty_clr got %b exp 0000", dirty_out); end
    checks++; if (commit_ack_out !== 1'b1) begin errors++; $display("FAIL basic_ack got %b exp 1", commit_ack_out); end
    idle(); step();
    checks++; if (commit_ack_out !== 1'b0) begin errors++; $display("FAIL basic_ack_drop got %b exp 0", commit_ack_out); end
  endtask

  task automatic test_write_commit();
    idle(); wr_en_in = 1'b1; wr_addr_in = 2'd1; wr_data_in = 8'h11; step();
    checks++; if (dirty_out !== 4'b0010) begin errors++; $display("FAIL wc_dirty1 got %b exp 0010", dirty_out); end
    wr_data_in = 8'h22; commit_in = 1'b1; step();
    checks++; if (q_out !== pack(RV, 8'h11, 8'hA5, RV)) begin errors++; $display("FAIL wc_q_old got %h exp %h", q_out, pack(RV, 8'h11, 8'hA5, RV)); end
    checks++; if (dirty_out !== 4'b0010) begin errors++; $display("FAIL wc_dirty2 got %b exp 0010", dirty_out); end
    checks++; if (commit_ack_out !== 1'b1) begin errors++; $display("FAIL wc_ack got %b exp 1", commit_ack_out); end
    idle(); rd_addr_in = 2'd1; step();
    checks++; if (rd_data_out !== 8'h22) begin errors++; $display("FAIL wc_rd got %h exp 22", rd_data_out); end
    checks++; if (q_out !== pack(RV, 8'h11, 8'hA5, RV)) begin errors++; $display("FAIL wc_q_stable got %h exp %h", q_out, pack(RV, 8'h11, 8'hA5, RV)); end
    commit_in = 1'b1; step();
    checks++; if (q_out !== pack(RV, 8'h22, 8'hA5, RV)) begin errors++; $display("FAIL wc_q_new got %h exp %h", q_out, pack(RV, 8'h22, 8'hA5, RV)); end
    checks++; if (dirty_out !== 4'b0000) begin errors++; $display("FAIL wc_dirty3 got %b exp 0000", dirty_out); end
  endtask

  task automatic test_priority();
    idle(); wr_en_in = 1'b1; clr_in = 1'b1; wr_addr_in = 2'd0; wr_data_in = 8'h3C; step();
    checks++; if (dirty_out !== 4'b0001) begin errors++; $display("FAIL prio_dirty got %b exp 0001", dirty_out); end
    wr_en_in = 1'b0; rd_addr_in = 2'd0; step();
    checks++; if (rd_data_out !== 8'h3C) begin errors++; $display("FAIL prio_wr_wins got %h exp 3C", rd_data_out); end
    checks++; if (dirty_out !== 4'b0001) begin errors++; $display("FAIL prio_clr_dirty got %b exp 0001", dirty_out); end
    idle(); step();
    checks++; if (rd_data_out !== RV) begin errors++; $display("FAIL prio_clr_val got %h exp %h", rd_data_out, RV); end
    checks++; if (q_out !== pack(RV, 8'h22, 8'hA5, RV)) begin errors++; $display("FAIL prio_q_stable got %h exp %h", q_out, pack(RV, 8'h22, 8'hA5, RV)); end
    commit_in = 1'b1; step(); idle(); step();
    checks++; if (dirty_out !== 4'b0000) begin errors++; $display("FAIL prio_dirty_clr got %b exp 0000", dirty_out); end
  endtask

  task automatic test_empty_commit();
    idle(); commit_in = 1'b1; step();
    checks++; if (commit_ack_out !== 1'b1) begin errors++; $display("FAIL empty_ack got %b exp 1", commit_ack_out); end
    checks++; if (q_out !== pack(RV, 8'h22, 8'hA5, RV)) begin errors++; $display("FAIL empty_q got %h exp %h", q_out, pack(RV, 8'h22, 8'hA5, RV)); end
    idle(); step();
    checks++; if (commit_ack_out !== 1'b0) begin errors++; $display("FAIL empty_ack_drop got %b exp 0", commit_ack_out); end
    commit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (commit_ack_out !== 1'b1) begin errors++; $display("FAIL held_ack_%0d got %b exp 1", i, commit_ack_out); end
    end
    idle(); step();
    checks++; if (commit_ack_out !== 1'b0) begin errors++; $display("FAIL held_ack_end got %b exp 0", commit_ack_out); end
  endtask

  task automatic test_readback();
    idle(); rd_addr_in = 2'd3; wr_en_in = 1'b1; wr_addr_in = 2'd3; wr_data_in = 8'h7E; step();
    checks++; if (rd_data_out !== RV) begin errors++; $display("FAIL rd_old got %h exp %h", rd_data_out, RV); end
    idle(); step();
    checks++; if (rd_data_out !== 8'h7E) begin errors++; $display("FAIL rd_new got %h exp 7E", rd_data_out); end
  endtask

  task automatic test_reset_mid();
    idle(); wr_en_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_addr_in = AW'(k); wr_data_in = WIDTH'(k + 1); step();
    end
    checks++; if (dirty_out !== 4'b1111) begin errors++; $display("FAIL mid_all_dirty got %b exp 1111", dirty_out); end
    wr_en_in = 1'b1; wr_addr_in = 2'd2; wr_data_in = 8'hEE;
    rst_in = 1'b1; commit_in = 1'b1; step();
    checks++; if (q_out !== pack(RV, RV, RV, RV)) begin errors++; $display("FAIL mid_q got %h exp %h", q_out, pack(RV, RV, RV, RV)); end
    checks++; if (dirty_out !== 4'b0000) begin errors++; $display("FAIL mid_dirty got %b exp 0000", dirty_out); end
    checks++; if (commit_ack_out !== 1'b0) begin errors++; $display("FAIL mid_ack got %b exp 0", commit_ack_out); end
    checks++; if (rd_data_out !== RV) begin errors++; $display("FAIL mid_rd got %h exp %h", rd_data_out, RV); end
    idle(); rd_addr_in = 2'd2; step();
    checks++; if (commit_ack_out !== 1'b0) begin errors++; $display("FAIL mid_ack_after got %b exp 0", commit_ack_out); end
    checks++; if (rd_data_out !== RV) begin errors++; $display("FAIL mid_shadow got %h exp %h", rd_data_out, RV); end
    checks++; if (q_out !== pack(RV, RV, RV, RV)) begin errors++; $display("FAIL mid_q_after got %h exp %h", q_out, pack(RV, RV, RV, RV)); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_write_commit();
    test_priority();
    test_empty_commit();
    test_readback();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
